ref_fetch: RTL and testbench

REF_FETCH -- requirements
Module: ref_fetch

---
 rtl/mpeg2_pkg.sv | 14 +
 rtl/addr_fifo.sv | 44 ++++
 rtl/ref_fetch.sv | 171 +++++++++++++++++
 tb/tb_ref_fetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg2_pkg.sv
package mpeg2_pkg;

  localparam int FETCH_DEPTH = 8;
  localparam int PIX_W       = 8;
  localparam int ADDR_W      = 32;
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);
  localparam int PTR_W       = $clog2(FETCH_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/addr_fifo.sv
import mpeg2_pkg::*;

module addr_fifo #(
  parameter int DATA_W = ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [FETCH_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign dout  = mem[rd_ptr[PTR_W-1:0]];

  // ---- storage and pointers: write at tail, read combinationally at head
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem[wr_ptr[PTR_W-1:0]] <= din;
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ref_fetch.sv
import mpeg2_pkg::*;

module ref_fetch #(
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [10:0]       stride,
  input  logic [9:0]        base_x,
  input  logic [8:0]        base_y,
  input  logic [3:0]        mx,
  input  logic [3:0]        my,
  input  logic              mreq,
  output logic              m_wait,
  output logic              m_valid,
  output logic [DATA_W-1:0] mq,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              idle
);

  function automatic logic [ADDR_W-1:0] calc_addr(
    input logic [ADDR_W-1:0] base,
    input logic [9:0]        row,
    input logic [10:0]       str,
    input logic [10:0]       col
  );
    logic [20:0] line_off;
    line_off = 21'(row) * 21'(str);
    return base + ADDR_W'(line_off) + ADDR_W'(col);
  endfunction

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [CNT_W-1:0]  inflight;
  logic              accept;
  logic              ret;

  logic [ADDR_W-1:0] cfg_base;
  logic [10:0]       cfg_stride;
  logic [9:0]        cfg_bx;
  logic [8:0]        cfg_by;

  logic              vld_p0;
  logic [9:0]        row_p0;
  logic [10:0]       col_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push_p1;
  logic              pop;

  assign accept  = mreq && !m_wait;
  assign ret     = avm_readdatavalid && (inflight != '0);
  assign push_p1 = vld_p1 && !fifo_full;
  assign pop     = avm_read && !avm_waitrequest;

  always_comb begin
    state_nxt = state;
    m_wait    = 1'b0;
    idle      = 1'b0;
    case (state)
      ST_IDLE: begin
        idle   = 1'b1;
        m_wait = load;
        if (accept) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        m_wait = (inflight == CNT_W'(FETCH_DEPTH));
        if ((inflight == CNT_W'(1)) && ret && !accept) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      inflight <= '0;
    end else begin
      state <= state_nxt;
      case ({accept, ret})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_base   <= '0;
      cfg_stride <= '0;
      cfg_bx     <= '0;
      cfg_by     <= '0;
    end else if ((state == ST_IDLE) && load) begin
      cfg_base   <= frame_base;
      cfg_stride <= stride;
      cfg_bx     <= base_x;
      cfg_by     <= base_y;
    end
  end

  // ---- stage p0: block origin plus in-block offset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      row_p0 <= 10'(cfg_by) + 10'(my);
      col_p0 <= 11'(cfg_bx) + 11'(mx);
    end
  end

  // ---- stage p1: linear byte address, pushed into the address queue next edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      addr_p1 <= calc_addr(cfg_base, row_p0, cfg_stride, col_p0);
    end
  end

  // ---- memory issue: queue head drives the read master
  addr_fifo #(
    .DATA_W (ADDR_W)
  ) u_addr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_p1),
    .din     (addr_p1),
    .pop     (pop),
    .dout    (avm_address),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign avm_read = !fifo_empty;

  // ---- return stage: in-order read data back to the requester
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      mq      <= '0;
    end else begin
      m_valid <= ret;
      if (ret) begin
        mq <= avm_readdata;
      end
    end
  end

endmodule

// File: tb/tb_ref_fetch.sv
module tb_ref_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [31:0] frame_base;
  logic [10:0] stride;
  logic [9:0]  base_x;
  logic [8:0]  base_y;
  logic [3:0]  mx;
  logic [3:0]  my;
  logic        mreq;
  logic        m_wait;
  logic        m_valid;
  logic [7:0]  mq;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [7:0]  avm_readdata = 8'h00;
  logic        avm_readdatavalid = 1'b0;
  logic        idle;

  always #5 clk = ~clk;

  ref_fetch dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .load              (load),
    .frame_base        (frame_base),
    .stride            (stride),
    .base_x            (base_x),
    .base_y            (base_y),
    .mx                (mx),
    .my                (my),
    .mreq              (mreq),
    .m_wait            (m_wait),
    .m_valid           (m_valid),
    .mq                (mq),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .idle              (idle)
  );

  int n_chk = 0;
  int n_fail = 0;
  int mv_cnt = 0;
  int max_inf = 0;

  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_stride = '0;
  logic [31:0] cfg_bx = '0;
  logic [31:0] cfg_by = '0;

  logic [31:0] addr_q[$];
  logic [7:0]  data_q[$];

  bit          mem_en = 1'b1;
  logic        stray_rdv = 1'b0;
  logic [7:0]  stray_data = 8'h00;
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [7:0]  pd0 = 8'h00, pd1 = 8'h00;
  logic        hs;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [3:0] x, input logic [3:0] y);
    return cfg_base + (cfg_by + 32'(y)) * cfg_stride + cfg_bx + 32'(x);
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Memory with 2-cycle read latency (or manual stray returns when mem_en=0)
  always @(negedge clk) begin
    hs = avm_read && !avm_waitrequest && reset_n;
    if (mem_en) begin
      avm_readdatavalid = pv1;
      avm_readdata      = pd1;
    end else begin
      avm_readdatavalid = stray_rdv;
      avm_readdata      = stray_data;
    end
    pv1 = pv0 && reset_n;
    pd1 = pd0;
    pv0 = hs && mem_en;
    pd0 = mem_byte(avm_address);
  end

  // Scoreboard: request addresses and returned bytes, in order
  always @(negedge clk) begin
    if (reset_n) begin
      if (mreq && !m_wait) addr_q.push_back(exp_addr(mx, my));
      if (avm_read && !avm_waitrequest) begin
        if (addr_q.size() == 0) check_eq("rd_unexpected", avm_read, 1'b0);
        else check_eq("avm_addr", avm_address, addr_q.pop_front());
        if (mem_en) data_q.push_back(mem_byte(avm_address));
      end
      if (m_valid) begin
        mv_cnt++;
        if (data_q.size() == 0) check_eq("mv_unexpected", m_valid, 1'b0);
        else check_eq("mq", mq, data_q.pop_front());
      end
      if (int'(dut.inflight) > max_inf) max_inf = int'(dut.inflight);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] b, input logic [10:0] s,
                         input logic [9:0] x, input logic [8:0] y);
    frame_base = b; stride = s; base_x = x; base_y = y; load = 1'b1;
    cfg_base = b; cfg_stride = 32'(s); cfg_bx = 32'(x); cfg_by = 32'(y);
    tick();
    load = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mreq = 1'b0; load = 1'b0; stray_rdv = 1'b0;
    tick();
    tick();
    addr_q.delete();
    data_q.delete();
    cfg_base = '0; cfg_stride = '0; cfg_bx = '0; cfg_by = '0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [3:0] x, input logic [3:0] y, output bit acc);
    mreq = 1'b1; mx = x; my = y; acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (!m_wait) acc = 1'b1;
      tick();
    end
    mreq = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    for (int c = 0; c < maxc && !idle; c++) tick();
    check_eq(tag, idle, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    bit          acc;
    bit          found;
    int          mv0;
    int          n;
    int          chg;
    bit          seen;
    logic [31:0] first;

    reset_n = 1'b0; load = 1'b0; mreq = 1'b0; mx = '0; my = '0;
    frame_base = '0; stride = '0; base_x = '0; base_y = '0;
    avm_waitrequest = 1'b0;

    @(negedge clk);
    check_eq("rst_idle",    idle, 1'b1);
    check_eq("rst_m_wait",  m_wait, 1'b0);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_avm_read", avm_read, 1'b0);
    check_eq("rst_avm_addr", avm_address, 32'h0);
    check_eq("rst_mq",      mq, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();

    // Single fetch with latency check; request during load is refused
    mv0 = mv_cnt;
    frame_base = 32'h1000; stride = 11'd640; base_x = 10'd16; base_y = 9'd8;
    cfg_base = 32'h1000; cfg_stride = 32'd640; cfg_bx = 32'd16; cfg_by = 32'd8;
    load = 1'b1; mreq = 1'b1; mx = 4'd3; my = 4'd2;
    @(negedge clk);
    check_eq("wait_during_load", m_wait, 1'b1);
    tick();
    load = 1'b0;
    @(negedge clk);
    check_eq("wait_after_load", m_wait, 1'b0);
    check_eq("idle_before_acc", idle, 1'b1);
    tick();
    mreq = 1'b0;
    @(negedge clk);
    check_eq("rd_after_T",  avm_read, 1'b0);
    check_eq("busy_after_T", idle, 1'b0);
    tick();
    @(negedge clk);
    check_eq("rd_after_T1", avm_read, 1'b0);
    tick();
    @(negedge clk);
    check_eq("rd_after_T2", avm_read, 1'b1);
    check_eq("addr_ref",    avm_address, 32'h0000_2913);
    tick();
    wait_idle("idle_single", 50);
    check_eq("mv_single", mv_cnt - mv0, 1);

    // Load while busy is ignored until a fresh load in idle
    do_load(32'h4000, 11'd100, 10'd5, 9'd1);
    avm_waitrequest = 1'b1;
    issue(4'd0, 4'd0, acc);
    check_eq("acc_busy0", acc, 1'b1);
    base_x = 10'd200; load = 1'b1;
    @(negedge clk);
    check_eq("wait_load_busy", m_wait, 1'b0);
    check_eq("busy_load", idle, 1'b0);
    tick();
    issue(4'd1, 4'd0, acc);
    check_eq("acc_busy1", acc, 1'b1);
    load = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("addr_old_cfg", avm_address, 32'h0000_4069);
    tick();
    avm_waitrequest = 1'b0;
    wait_idle("idle_busyload", 50);
    do_load(32'h4000, 11'd100, 10'd200, 9'd1);
    issue(4'd1, 4'd0, acc);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (avm_read) begin
        found = 1'b1;
        check_eq("addr_new_cfg", avm_address, 32'h0000_412D);
      end
      tick();
    end
    check_eq("read_seen", found, 1'b1);
    wait_idle("idle_newcfg", 50);

    // 256 back-to-back requests with row/col carry and 32-bit wrap
    do_load(32'hFFFF_0000, 11'd1280, 10'd1020, 9'd510);
    mv0 = mv_cnt;
    n = 0;
    mreq = 1'b1; mx = 4'(n); my = 4'(n >> 4);
    for (int c = 0; c < 4000 && n < 256; c++) begin
      @(negedge clk);
      if (!m_wait) n++;
      tick();
      mx = 4'(n); my = 4'(n >> 4);
    end
    mreq = 1'b0;
    check_eq("b2b_accepts", n, 256);
    wait_idle("idle_b2b", 400);
    check_eq("b2b_mvalid", mv_cnt - mv0, 256);
    check_eq("b2b_inflight_cap", max_inf > 8, 1'b0);
    check_eq("b2b_drained", data_q.size(), 0);

    // Stalled memory: cap at 8, address held, nothing returned
    do_load(32'h8000, 11'd64, 10'd0, 9'd0);
    avm_waitrequest = 1'b1;
    mv0 = mv_cnt; n = 0; chg = 0; seen = 1'b0; first = '0;
    mreq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mx = 4'(n);
      @(negedge clk);
      if (!m_wait) n++;
      if (avm_read) begin
        if (!seen) begin first = avm_address; seen = 1'b1; end
        else if (avm_address !== first) chg++;
      end
      tick();
    end
    @(negedge clk);
    check_eq("stall_accepts", n, 8);
    check_eq("stall_m_wait",  m_wait, 1'b1);
    check_eq("stall_read",    avm_read, 1'b1);
    check_eq("stall_addr",    avm_address, 32'h0000_8000);
    check_eq("stall_addr_changes", chg, 0);
    check_eq("stall_no_mvalid", mv_cnt - mv0, 0);
    tick();
    mreq = 1'b0;
    avm_waitrequest = 1'b0;
    wait_idle("idle_stall", 100);
    check_eq("stall_mvalid", mv_cnt - mv0, 8);

    // Full counter with concurrent returns and accepts
    mem_en = 1'b0;
    mv0 = mv_cnt;
    mreq = 1'b1; mx = 4'd0; my = 4'd0;
    repeat (12) tick();
    @(negedge clk);
    check_eq("full_inflight", dut.inflight, 4'd8);
    check_eq("full_m_wait",   m_wait, 1'b1);
    tick();
    stray_rdv = 1'b1; stray_data = 8'hA5; data_q.push_back(8'hA5);
    @(negedge clk);
    check_eq("full_wait_at_rdv", m_wait, 1'b1);
    tick();
    stray_data = 8'h5A; data_q.push_back(8'h5A);
    @(negedge clk);
    check_eq("rdv_only_inflight", dut.inflight, 4'd7);
    check_eq("rdv_only_m_wait",   m_wait, 1'b0);
    tick();
    stray_rdv = 1'b0;
    @(negedge clk);
    check_eq("acc_rdv_inflight", dut.inflight, 4'd7);
    check_eq("acc_rdv_m_wait",   m_wait, 1'b0);
    tick();
    @(negedge clk);
    check_eq("refill_inflight", dut.inflight, 4'd8);
    check_eq("refill_m_wait",   m_wait, 1'b1);
    tick();
    @(negedge clk);
    check_eq("hold_inflight", dut.inflight, 4'd8);
    check_eq("hold_m_wait",   m_wait, 1'b1);
    tick();
    mreq = 1'b0;
    repeat (2) tick();
    check_eq("full_mvalid", mv_cnt - mv0, 2);

    // Async reset with 5 outstanding, then stray returns
    do_reset();
    do_load(32'h100, 11'd16, 10'd0, 9'd0);
    n = 0;
    mreq = 1'b1;
    for (int i = 0; i < 20 && n < 5; i++) begin
      mx = 4'(n);
      @(negedge clk);
      if (!m_wait) n++;
      tick();
    end
    mreq = 1'b0;
    repeat (4) tick();
    check_eq("pre_rst_inflight", dut.inflight, 4'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_idle",     idle, 1'b1);
    check_eq("async_rst_inflight", dut.inflight, 4'd0);
    check_eq("async_rst_read",     avm_read, 1'b0);
    addr_q.delete();
    data_q.delete();
    tick();
    reset_n = 1'b1;
    mv0 = mv_cnt;
    stray_rdv = 1'b1; stray_data = 8'hEE;
    repeat (5) tick();
    stray_rdv = 1'b0;
    repeat (3) tick();
    check_eq("stray_no_mvalid", mv_cnt - mv0, 0);
    check_eq("stray_idle",      idle, 1'b1);
    check_eq("stray_inflight",  dut.inflight, 4'd0);
    check_eq("stray_m_wait",    m_wait, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
